// File: rtl/sys_pulse_gen.sv
// Programmable pulse-train generator driven by four config registers.
// Period, width, count and mode are shadowed on an accepted start edge.
module sys_pulse_gen #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] reg_0,
    input  logic [DATA_WIDTH-1:0] reg_1,
    input  logic [DATA_WIDTH-1:0] reg_2,
    input  logic [DATA_WIDTH-1:0] reg_3,
    output logic                  pulse_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [DATA_WIDTH-1:0] pulse_num
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic                  cont_q, cont_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] w_q, w_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] ph_q, ph_d;
    logic [DATA_WIDTH-1:0] pnum_q, pnum_d;
    logic                  pulse_q, pulse_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  start_edge;
    logic                  bad_cfg;
    logic [DATA_WIDTH-1:0] ph_inc;
    logic [DATA_WIDTH-1:0] pnum_inc;
    logic                  unused_ctrl_bits;

    always_comb begin
        unused_ctrl_bits = ^reg_0[DATA_WIDTH-1:3];
    end

    always_comb begin
        start_edge = reg_0[1] & ~start_q;
        bad_cfg    = (reg_1 == '0) || ((reg_3 == '0) && !reg_0[2]);
        ph_inc     = ph_q + ONE;
        pnum_inc   = pnum_q + ONE;

        state_d   = state_q;
        start_d   = reg_0[1];
        cont_d    = cont_q;
        p_d       = p_q;
        w_d       = w_q;
        c_d       = c_q;
        ph_d      = ph_q;
        pnum_d    = pnum_q;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge && reg_0[0]) begin
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        p_d     = reg_1;
                        w_d     = reg_2;
                        c_d     = reg_3;
                        cont_d  = reg_0[2];
                        ph_d    = '0;
                        pnum_d  = '0;
                        pulse_d = (reg_2 != '0);
                    end
                end
            end
            RUN: begin
                // pulse_q is registered, so it is computed from the phase the next cycle will hold
                if (!reg_0[0]) begin
                    state_d = IDLE;
                end else if (ph_inc == p_q) begin
                    pnum_d = pnum_inc;
                    if (!cont_q && (pnum_inc == c_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ph_d    = '0;
                        pulse_d = (w_q != '0);
                    end
                end else begin
                    ph_d    = ph_inc;
                    pulse_d = (ph_inc < w_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            cont_q    <= 1'b0;
            p_q       <= '0;
            w_q       <= '0;
            c_q       <= '0;
            ph_q      <= '0;
            pnum_q    <= '0;
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            cont_q    <= cont_d;
            p_q       <= p_d;
            w_q       <= w_d;
            c_q       <= c_d;
            ph_q      <= ph_d;
            pnum_q    <= pnum_d;
            pulse_q   <= pulse_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        pulse_out = pulse_q;
        busy      = (state_q == RUN);
        done      = done_q;
        cfg_err   = cfg_err_q;
        pulse_num = pnum_q;
    end

endmodule

// File: tb/tb_sys_pulse_gen.sv
// Directed self-checking bench for sys_pulse_gen.
module tb_sys_pulse_gen;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] reg_0, reg_1, reg_2, reg_3;
    logic          pulse_out, busy, done, cfg_err;
    logic [DW-1:0] pulse_num;

    int vectors;
    int miscompares;

    sys_pulse_gen #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_0    (reg_0),
        .reg_1    (reg_1),
        .reg_2    (reg_2),
        .reg_3    (reg_3),
        .pulse_out(pulse_out),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .pulse_num(pulse_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rstn  = 1'b0;
        reg_0 = '0;
        reg_1 = '0;
        reg_2 = '0;
        reg_3 = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({pulse_out, busy, done, cfg_err} !== 4'b0000 || pulse_num !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got p=%b b=%b d=%b e=%b n=%0d exp all 0",
                     pulse_out, busy, done, cfg_err, pulse_num);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_p, exp_b, exp_d;
        reg_1 = 4; reg_2 = 2; reg_3 = 3; reg_0 = 32'h1;
        @(negedge clk);
        reg_0 = 32'h3;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_b = (k <= 12);
            exp_p = exp_b && (((k - 1) % 4) < 2);
            exp_d = (k == 13);
            vectors++;
            if (pulse_out !== exp_p) begin
                miscompares++;
                $display("FAIL basic_pulse k=%0d got %b exp %b", k, pulse_out, exp_p);
            end
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL basic_busy k=%0d got %b exp %b", k, busy, exp_b);
            end
            vectors++;
            if (done !== exp_d) begin
                miscompares++;
                $display("FAIL basic_done k=%0d got %b exp %b", k, done, exp_d);
            end
            vectors++;
            if (pulse_num !== DW'((k - 1) / 4)) begin
                miscompares++;
                $display("FAIL basic_pnum k=%0d got %0d exp %0d", k, pulse_num, (k - 1) / 4);
            end
        end
        reg_0 = 32'h1;
        @(negedge clk);
    endtask

    task automatic test_clamp();
        reg_1 = 3; reg_2 = 5; reg_3 = 2;
        reg_0 = 32'h3;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            vectors++;
            if (pulse_out !== (k <= 6) || busy !== (k <= 6) || done !== (k == 7)) begin
                miscompares++;
                $display("FAIL clamp k=%0d got p=%b b=%b d=%b exp p=%b b=%b d=%b",
                         k, pulse_out, busy, done, k <= 6, k <= 6, k == 7);
            end
        end
        vectors++;
        if (pulse_num !== 2) begin
            miscompares++;
            $display("FAIL clamp_pnum got %0d exp 2", pulse_num);
        end
        reg_0 = 32'h1;
        @(negedge clk);
    endtask

    task automatic test_rejects();
        // P == 0
        reg_1 = 0; reg_2 = 1; reg_3 = 1;
        reg_0 = 32'h3;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++;
            if (cfg_err !== (k == 1) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rej_p0 k=%0d got e=%b b=%b exp e=%b b=0", k, cfg_err, busy, k == 1);
            end
        end
        vectors++;
        if (pulse_num !== 2) begin
            miscompares++;
            $display("FAIL rej_pnum_hold got %0d exp 2", pulse_num);
        end
        reg_0 = 32'h1;
        @(negedge clk);
        // C == 0 in count mode
        reg_1 = 4; reg_3 = 0;
        reg_0 = 32'h3;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++;
            if (cfg_err !== (k == 1) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rej_c0 k=%0d got e=%b b=%b exp e=%b b=0", k, cfg_err, busy, k == 1);
            end
        end
        // enable low: edge ignored silently
        reg_3 = 3;
        reg_0 = 32'h0;
        @(negedge clk);
        reg_0 = 32'h2;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rej_noen k=%0d got e=%b b=%b exp e=0 b=0", k, cfg_err, busy);
            end
        end
        reg_0 = 32'h1;
        @(negedge clk);
    endtask

    task automatic test_abort_shadow();
        logic exp_p;
        reg_1 = 10; reg_2 = 5; reg_3 = 100;
        reg_0 = 32'h3;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_p = (((k - 1) % 10) < 5);
            vectors++;
            if (pulse_out !== exp_p || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL shadow k=%0d got p=%b b=%b exp p=%b b=1", k, pulse_out, busy, exp_p);
            end
            if (k == 3) reg_1 = 2;
        end
        reg_0 = 32'h0;
        for (int k = 26; k <= 27; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || pulse_num !== 2) begin
                miscompares++;
                $display("FAIL abort k=%0d got b=%b p=%b d=%b n=%0d exp b=0 p=0 d=0 n=2",
                         k, busy, pulse_out, done, pulse_num);
            end
        end
    endtask

    task automatic test_continuous();
        reg_1 = 2; reg_2 = 1; reg_3 = 0;
        reg_0 = 32'h5;
        @(negedge clk);
        reg_0 = 32'h7;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            vectors++;
            if (pulse_out !== (k % 2 == 1) || busy !== 1'b1 || cfg_err !== 1'b0 ||
                pulse_num !== DW'((k - 1) / 2)) begin
                miscompares++;
                $display("FAIL cont k=%0d got p=%b b=%b e=%b n=%0d exp p=%b b=1 e=0 n=%0d",
                         k, pulse_out, busy, cfg_err, pulse_num, k % 2 == 1, (k - 1) / 2);
            end
        end
        reg_0 = 32'h6;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || pulse_num !== 50) begin
            miscompares++;
            $display("FAIL cont_stop got b=%b p=%b d=%b n=%0d exp b=0 p=0 d=0 n=50",
                     busy, pulse_out, done, pulse_num);
        end
        reg_0 = 32'h1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        reg_1 = 2; reg_2 = 1; reg_3 = 1;
        reg_0 = 32'h3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (k != 3 && k != 6 ? 1'b1 : 1'b0) ||
                pulse_out !== (k == 1 || k == 4) || done !== (k == 3 || k == 6)) begin
                miscompares++;
                $display("FAIL b2b k=%0d got b=%b p=%b d=%b", k, busy, pulse_out, done);
            end
            if (k == 4) begin
                vectors++;
                if (pulse_num !== 0) begin
                    miscompares++;
                    $display("FAIL b2b_pnum_clear got %0d exp 0", pulse_num);
                end
            end
            if (k == 1) reg_0 = 32'h1;
            if (k == 3) reg_0 = 32'h3;
            if (k == 4) reg_0 = 32'h1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        reg_1 = 4; reg_2 = 2; reg_3 = 3;
        reg_0 = 32'h3;
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || pulse_out !== 1'b1 || pulse_num !== 1) begin
            miscompares++;
            $display("FAIL midrun_pre got b=%b p=%b n=%0d exp b=1 p=1 n=1", busy, pulse_out, pulse_num);
        end
        #2 rstn = 1'b0;
        #1;
        vectors++;
        if ({pulse_out, busy, done, cfg_err} !== 4'b0000 || pulse_num !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset got p=%b b=%b d=%b e=%b n=%0d exp all 0",
                     pulse_out, busy, done, cfg_err, pulse_num);
        end
        reg_0 = 32'h1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        reg_0 = 32'h3;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (k <= 12) || done !== (k == 13) ||
                pulse_out !== ((k <= 12) && (((k - 1) % 4) < 2))) begin
                miscompares++;
                $display("FAIL rerun k=%0d got b=%b d=%b p=%b", k, busy, done, pulse_out);
            end
        end
        vectors++;
        if (pulse_num !== 3) begin
            miscompares++;
            $display("FAIL rerun_pnum got %0d exp 3", pulse_num);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_clamp();
        test_rejects();
        test_abort_shadow();
        test_continuous();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sys_pulse_gen.md
# sys_pulse_gen

Programmable pulse-train generator driven directly by the four system configuration registers (reg_0..reg_3) produced by the BRAM-mapped config block. Software writes period, high width and pulse count, then toggles a start bit. The block emits a registered pulse train, reports busy/done status and a completed-period count. Configuration is shadowed at start, so register writes during a run do not disturb the train.

## Interface
- DATA_WIDTH, 32: width of each config register, the internal counters and the pulse_num output.
- clk  in  1  system clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- reg_0  in  DATA_WIDTH  control register.
  - bit0 = enable.
  - bit1 = start; the rising edge is the trigger.
  - bit2 = continuous mode.
  - Other bits are ignored.
- reg_1  in  DATA_WIDTH  period P, in clk cycles.
- reg_2  in  DATA_WIDTH  high width W, in clk cycles.
- reg_3  in  DATA_WIDTH  pulse count C; ignored in continuous mode.
- pulse_out  out  1  pulse train; driven from a register.
- busy  out  1  high while a train is running.
- done  out  1  one-cycle strobe on normal completion.
- cfg_err  out  1  one-cycle strobe when a start is rejected.
- pulse_num  out  DATA_WIDTH  number of periods completed in the current or last run.

## Operation
- States:
  - IDLE: busy=0, pulse_out=0.
  - RUN: busy=1.
- Start edge detection: a 1-bit register start_d holds reg_0[1]. A start edge exists in cycle N when reg_0[1]=1 and start_d=0.
- Start accept: requires a start edge in IDLE with reg_0[0]=1. On accept:
  - Shadow P, W, C and the mode bit.
  - Clear pulse_num.
  - Clear phase counter ph.
  - Move to RUN.
- Start reject: a start edge in IDLE with reg_0[0]=1 and P==0, or (C==0 and continuous=0). The block pulses cfg_err for one cycle and stays in IDLE.
- Other start edges:
  - Edges while RUN are ignored.
  - A start edge with enable=0 is ignored, and no cfg_err is raised.
- RUN behaviour:
  - ph counts 0..P-1 and wraps.
  - pulse_out=1 when ph < W, else 0.
  - W >= P gives pulse_out held high for the whole run.
  - W == 0 gives pulse_out low for the whole run; this is legal, not an error.
- Period completion: each wrap of ph (ph==P-1) increments pulse_num.
  - In count mode, the wrap that makes pulse_num==C_shadow returns the block to IDLE and strobes done in the next cycle.
  - In continuous mode, pulse_num wraps modulo 2^DATA_WIDTH and the run never ends by count.
- Abort: reg_0[0]=0 sampled in RUN forces IDLE on the next cycle.
  - pulse_out=0 and busy=0 on that cycle.
  - done is not asserted.
  - pulse_num holds its value.
- Live register changes: changes to reg_1..reg_3 or reg_0[2] during RUN have no effect until the next accepted start.
- Reset mid-run: the block is in IDLE immediately, with all outputs at their reset values.
- Reset values: pulse_out=0, busy=0, done=0, cfg_err=0, pulse_num=0, start_d=0, state IDLE.

## Timing
- Start edge sampled in cycle N, then:
  - busy=1 and ph=0 from N+1.
  - The first pulse_out high cycle is N+1 (if W>0).
- pulse_out is high in cycles N+1+k·P .. N+k·P+min(W,P), for k = 0..C-1.
- Count-mode run:
  - busy high in cycles N+1 .. N+P·C.
  - done=1 and busy=0 in cycle N+P·C+1.
  - pulse_num=C from cycle N+P·C+1.
- pulse_num updates in the cycle after each ph==P-1 cycle.
- cfg_err is high in cycle N+1 for a rejected edge in cycle N.
- A start edge occurring in the done cycle is accepted; the new run has busy=1 on the following cycle.
- Abort: reg_0[0]=0 in RUN cycle M gives busy=0 and pulse_out=0 in M+1.

## Test plan
- Basic train: reg_1=4, reg_2=2, reg_3=3, reg_0 goes 0x1 then 0x3 at cycle N. Expected response:
  - pulse_out high at N+1,N+2, N+5,N+6, N+9,N+10.
  - busy N+1..N+12.
  - done at N+13, pulse_num=3.
- Clamp: P=3, W=5, C=2. pulse_out high N+1..N+6 with no gap; done at N+7.
- Rejects:
  - P=0 with enable=1 gives cfg_err at N+1, busy stays 0.
  - C=0 in count mode gives the same response.
  - Start with enable=0 gives neither cfg_err nor busy.
- Abort and shadowing: P=10, W=5, C=100.
  - Rewrite reg_1=2 at N+3; the period remains 10.
  - Clear enable at N+25: busy=0 and pulse_out=0 at N+26, no done, pulse_num=2.
- Continuous mode: reg_0=0x5 then 0x7, P=2, W=1, C=0.
  - Runs without cfg_err, toggling 1,0.
  - Holding reg_0[1]=1 does not retrigger.
  - pulse_num=50 after 100 cycles.
  - Clearing enable stops the train.
- Reset mid-run: assert rstn=0 during RUN. All outputs are zero immediately; after release, a new start edge runs normally.
